// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its instruction memory port.
//   - Memory request/response message structs for 32-bit address, 32-bit
//     data and an 8-bit opaque field. Fields: {op, opaque, addr, len, data}.
//   - Memory op encodings.
// A len of 0 means a full-word access.
package fetch_unit_pkg;

    localparam int MEM_OP_BITS   = 3;
    localparam int MEM_OPAQ_BITS = 8;
    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_LEN_BITS  = 2;
    localparam int MEM_DATA_BITS = 32;

    localparam logic [MEM_OP_BITS-1:0] MEM_MSG_READ  = 3'd0;
    localparam logic [MEM_OP_BITS-1:0] MEM_MSG_WRITE = 3'd1;

    typedef struct packed {
        logic [MEM_OP_BITS-1:0]   op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_LEN_BITS-1:0]  len;
        logic [MEM_DATA_BITS-1:0] data;
    } t_mem_req_msg_32_32_8;

    typedef struct packed {
        logic [MEM_OP_BITS-1:0]   op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_LEN_BITS-1:0]  len;
        logic [MEM_DATA_BITS-1:0] data;
    } t_mem_resp_msg_32_32_8;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Keeps the PC, issues word reads to instruction memory and forwards each
// returned instruction with its PC straight to decode (no buffering).
// Branch redirects from decode bump an epoch; the epoch travels in the memory
// opaque field so wrong-path responses can be recognised and dropped.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_req_val/rdy/msg           read requests to instruction memory
//   mem_resp_val/rdy/msg          in-order responses from instruction memory
//   D_val/rdy, D_inst, D_pc       instruction + PC handed to decode
//   D_branch_val/target           redirect request from decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] p_rst_addr  = 32'h0,
    parameter int          p_addr_bits = 32,
    parameter int          p_inst_bits = 32,
    parameter int          p_opaq_bits = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output t_mem_req_msg_32_32_8   mem_req_msg,

    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  t_mem_resp_msg_32_32_8  mem_resp_msg,

    output logic                   D_val,
    input  logic                   D_rdy,
    output logic [p_inst_bits-1:0] D_inst,
    output logic [p_addr_bits-1:0] D_pc,

    input  logic                   D_branch_val,
    input  logic [p_addr_bits-1:0] D_branch_target
);

    // At most this many requests may be waiting for a response.
    localparam logic [2:0] MAX_INFLIGHT = 3'd4;

    logic [p_addr_bits-1:0] pc_reg;
    logic [p_opaq_bits-1:0] epoch_reg;
    logic [2:0]             inflight_reg;

    logic stale;
    logic req_fire;
    logic resp_fire;

    // op and len of a response carry nothing the fetch stage needs.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{mem_resp_msg.op, mem_resp_msg.len};

    always_comb begin
        // A response tagged with an older epoch belongs to a wrong path.
        stale = (mem_resp_msg.opaque != epoch_reg);

        // The redirect cycle issues nothing: pc is about to change.
        mem_req_val        = !rst && !D_branch_val && (inflight_reg < MAX_INFLIGHT);
        mem_req_msg        = '0;
        mem_req_msg.op     = MEM_MSG_READ;
        mem_req_msg.opaque = epoch_reg;
        mem_req_msg.addr   = pc_reg;
        mem_req_msg.len    = '0;
        mem_req_msg.data   = '0;

        // Stale responses are always drained; live ones wait for decode.
        mem_resp_rdy = !rst && (stale || D_rdy);
        D_val        = !rst && mem_resp_val && !stale;
        D_inst       = mem_resp_msg.data;
        D_pc         = mem_resp_msg.addr;
    end

    assign req_fire  = mem_req_val && mem_req_rdy;
    assign resp_fire = mem_resp_val && mem_resp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= p_addr_bits'(p_rst_addr);
            epoch_reg    <= '0;
            inflight_reg <= '0;
        end else begin
            if (D_branch_val) begin
                pc_reg    <= D_branch_target;
                epoch_reg <= epoch_reg + p_opaq_bits'(1);
            end else if (req_fire) begin
                pc_reg    <= pc_reg + p_addr_bits'(4);
            end

            // A request and a response in the same cycle cancel out.
            case ({req_fire, resp_fire})
                2'b10:   inflight_reg <= inflight_reg + 3'd1;
                2'b01:   inflight_reg <= inflight_reg - 3'd1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order instruction memory model with configurable
// latency, decode-side ready/redirect driver and a scoreboard of expected
// (inst, pc) pairs that is popped on every decode accept.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  mem_req_val;
    logic                  mem_req_rdy = 1'b1;
    t_mem_req_msg_32_32_8  mem_req_msg;
    logic                  mem_resp_val = 1'b0;
    logic                  mem_resp_rdy;
    t_mem_resp_msg_32_32_8 mem_resp_msg = '0;
    logic                  D_val;
    logic                  D_rdy = 1'b1;
    logic [31:0]           D_inst;
    logic [31:0]           D_pc;
    logic                  D_branch_val = 1'b0;
    logic [31:0]           D_branch_target = 32'h0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_val     (mem_req_val),
        .mem_req_rdy     (mem_req_rdy),
        .mem_req_msg     (mem_req_msg),
        .mem_resp_val    (mem_resp_val),
        .mem_resp_rdy    (mem_resp_rdy),
        .mem_resp_msg    (mem_resp_msg),
        .D_val           (D_val),
        .D_rdy           (D_rdy),
        .D_inst          (D_inst),
        .D_pc            (D_pc),
        .D_branch_val    (D_branch_val),
        .D_branch_target (D_branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } t_exp;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  opaque;
        int          due;
    } t_pend;

    t_exp        sb_q[$];
    t_pend       pend_q[$];
    logic [31:0] mem_words [logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 0;
    int max_infl = 0;
    int drops    = 0;
    int hold     = 0;
    bit sb_on    = 1'b0;
    bit bp_on    = 1'b0;
    bit br_armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_words.exists(a))
            return mem_words[a];
        return a ^ 32'h5a5a_0000;
    endfunction

    task automatic expect_at(input logic [31:0] a);
        t_exp e;
        e.inst = mem_rd(a);
        e.pc   = a;
        sb_q.push_back(e);
    endtask

    // Memory model and decode driver. Handshakes are observed at negedge
    // (they complete at the following posedge); inputs change just after
    // the posedge.
    always begin
        @(negedge clk);
        if (!rst) begin
            if (mem_resp_val && mem_resp_rdy) begin
                if (!D_val)
                    drops++;
                void'(pend_q.pop_front());
            end
            if (mem_req_val && mem_req_rdy) begin
                t_pend p;
                p.addr   = mem_req_msg.addr;
                p.opaque = mem_req_msg.opaque;
                p.due    = cyc + 1 + lat;
                pend_q.push_back(p);
            end
            if (pend_q.size() > max_infl)
                max_infl = pend_q.size();
            if (D_val && D_rdy) begin
                $display("D accept pc=%h inst=%h", D_pc, D_inst);
                if (bp_on)
                    hold = 3;
                if (sb_on) begin
                    check("sb_level", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        t_exp e;
                        e = sb_q.pop_front();
                        check("d_inst", D_inst, e.inst);
                        check("d_pc", D_pc, e.pc);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            mem_resp_val        = 1'b1;
            mem_resp_msg.op     = MEM_MSG_READ;
            mem_resp_msg.opaque = pend_q[0].opaque;
            mem_resp_msg.addr   = pend_q[0].addr;
            mem_resp_msg.len    = 2'd0;
            mem_resp_msg.data   = mem_rd(pend_q[0].addr);
        end else begin
            mem_resp_val = 1'b0;
            mem_resp_msg = '0;
        end
        if (bp_on && hold > 0) begin
            D_rdy = 1'b0;
            hold--;
        end else begin
            D_rdy = 1'b1;
        end
        #1;
        if (br_armed && D_val) begin
            D_branch_val = 1'b1;
            br_armed     = 1'b0;
            #1;
            check("req_blocked_on_branch", 32'(mem_req_val), 32'd0);
        end else begin
            D_branch_val = 1'b0;
        end
    end

    // Asserts reset (asynchronously, wherever we are in the cycle), checks the
    // outputs drop at once, resets the memory model, and releases reset
    // between edges so the first request appears in the very next cycle.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req_val", 32'(mem_req_val), 32'd0);
        check("rst_resp_rdy", 32'(mem_resp_rdy), 32'd0);
        check("rst_d_val", 32'(D_val), 32'd0);
        pend_q.delete();
        sb_q.delete();
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        bp_on    = 1'b0;
        br_armed = 1'b0;
        hold     = 0;
        max_infl = 0;
        drops    = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("first_req_val", 32'(mem_req_val), 32'd1);
        check("first_req_addr", mem_req_msg.addr, 32'h0);
        check("first_req_opaque", 32'(mem_req_msg.opaque), 32'd0);
        check("first_req_op", 32'(mem_req_msg.op), 32'(MEM_MSG_READ));
    endtask

    task automatic drain(input string tag);
        sb_on = 1'b1;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
        sb_on = 1'b0;
    endtask

    initial begin
        mem_words[32'h0]   = 32'hdeadbeef;

        // Basic single instruction.
        lat = 0;
        do_reset();
        expect_at(32'h0);
        drain("basic");

        // Sequential fetch with zero-delay memory.
        mem_words[32'h0] = 32'd11;
        mem_words[32'h4] = 32'd22;
        mem_words[32'h8] = 32'd33;
        @(negedge clk);
        do_reset();
        for (int a = 0; a < 12; a += 4) expect_at(32'(a));
        drain("seq");

        // Three-cycle memory: in-flight count saturates at 4.
        lat = 3;
        @(negedge clk);
        do_reset();
        for (int a = 0; a < 32; a += 4) expect_at(32'(a));
        drain("delay");
        check("delay_max_inflight", 32'(max_infl), 32'd4);

        // Decode backpressure: 3 idle cycles between accepts.
        lat = 1;
        @(negedge clk);
        do_reset();
        bp_on = 1'b1;
        for (int a = 0; a < 24; a += 4) expect_at(32'(a));
        drain("bp");
        check("bp_max_inflight", 32'(max_infl), 32'd4);

        // Redirect on the first accept; wrong-path 4 and 8 must be dropped.
        lat = 2;
        mem_words[32'h100] = 32'hcafef00d;
        D_branch_target = 32'h100;
        @(negedge clk);
        do_reset();
        br_armed = 1'b1;
        expect_at(32'h0);
        expect_at(32'h100);
        expect_at(32'h104);
        drain("redirect");
        check("redirect_drops", 32'(drops), 32'd2);

        // Reset in the middle of fetching with requests outstanding.
        lat = 3;
        @(negedge clk);
        do_reset();
        repeat (5) @(posedge clk);
        #3;
        check("midrst_resp_pending", 32'(mem_resp_val), 32'd1);
        do_reset();
        for (int a = 0; a < 12; a += 4) expect_at(32'(a));
        drain("midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
